// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation codes plus the operand sequencer's state
// encoding and debounce default.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [2:0] {
    SEQ_ENTER_A  = 3'd0,
    SEQ_ENTER_B  = 3'd1,
    SEQ_ENTER_OP = 3'd2,
    SEQ_EXEC     = 3'd3,
    SEQ_SHOW     = 3'd4
  } seq_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  function automatic logic aluop_defined(logic [3:0] code);
    return code <= 4'(ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus: operands and op code out to the ALU, result and flags back.
interface alu_operand_sequencer_if;

  logic [31:0]           Port_A;
  logic [31:0]           Port_B;
  cpu_types_pkg::aluop_t ALUOP;
  logic [31:0]           alu_out;
  logic                  alu_zero;
  logic                  alu_neg;
  logic                  alu_ovf;

  modport master (
    output Port_A, Port_B, ALUOP,
    input  alu_out, alu_zero, alu_neg, alu_ovf
  );

  modport slave (
    input  Port_A, Port_B, ALUOP,
    output alu_out, alu_zero, alu_neg, alu_ovf
  );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low push-button; emits a one-cycle
// registered pulse on each accepted press (1->0 of the debounced level).
module key_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   sync;
  logic                   cnt_done;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(key_n);
      press_q <= 1'b0;
      if (sync == level_q) begin
        cnt_q <= '0;
      end else if (cnt_done) begin
        level_q <= sync;
        cnt_q   <= '0;
        press_q <= level_q & ~sync;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front end for the board ALU: debounced key-driven entry of A, B and op,
// one-cycle execute, then result/flag capture and display muxing.
module alu_operand_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [17:0]                    sw,
  input  logic                           key_enter_n,
  input  logic                           key_clear_n,
  alu_operand_sequencer_if.master        alu,
  output logic [31:0]                    result_q,
  output logic                           zero_q,
  output logic                           neg_q,
  output logic                           ovf_q,
  output logic                           result_valid,
  output logic [2:0]                     state_o,
  output logic [31:0]                    disp_value
);

  localparam logic [2:0] ST_ENTER_A  = SEQ_ENTER_A;
  localparam logic [2:0] ST_ENTER_B  = SEQ_ENTER_B;
  localparam logic [2:0] ST_ENTER_OP = SEQ_ENTER_OP;
  localparam logic [2:0] ST_EXEC     = SEQ_EXEC;
  localparam logic [2:0] ST_SHOW     = SEQ_SHOW;

  logic        enter_press, clear_press, enter_level, clear_level;
  logic [31:0] opnd;
  logic [2:0]  state_q, state_d;
  logic [31:0] port_a_q, port_a_d, port_b_q, port_b_d, result_d;
  aluop_t      aluop_q, aluop_d;
  logic        zero_d, neg_d, ovf_d, valid_q, valid_d;
  logic        unused_bits;

  assign unused_bits = sw[17] ^ enter_level ^ clear_level;
  assign opnd        = {{16{sw[16]}}, sw[15:0]};

  key_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_enter_n),
    .level (enter_level),
    .press (enter_press)
  );

  key_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_clear_n),
    .level (clear_level),
    .press (clear_press)
  );

  always_comb begin
    state_d  = state_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    aluop_d  = aluop_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_ENTER_A: if (enter_press) begin
        port_a_d = opnd;
        state_d  = ST_ENTER_B;
      end
      ST_ENTER_B: if (enter_press) begin
        port_b_d = opnd;
        state_d  = ST_ENTER_OP;
      end
      ST_ENTER_OP: if (enter_press) begin
        aluop_d = aluop_defined(sw[3:0]) ? aluop_t'(sw[3:0]) : ALU_SLL;
        state_d = ST_EXEC;
      end
      // Operands were registered on the previous edge, so alu_out is settled.
      ST_EXEC: begin
        result_d = alu.alu_out;
        zero_d   = alu.alu_zero;
        neg_d    = alu.alu_neg;
        ovf_d    = alu.alu_ovf;
        state_d  = ST_SHOW;
      end
      ST_SHOW: if (enter_press) state_d = ST_ENTER_A;
      default: state_d = ST_ENTER_A;
    endcase
    if (clear_press) begin
      state_d  = ST_ENTER_A;
      port_a_d = '0;
      port_b_d = '0;
      aluop_d  = ALU_SLL;
      result_d = '0;
      zero_d   = 1'b0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
    end
    valid_d = (state_d == ST_SHOW);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_ENTER_A;
      port_a_q <= '0;
      port_b_q <= '0;
      aluop_q  <= ALU_SLL;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
      aluop_q  <= aluop_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign alu.Port_A   = port_a_q;
  assign alu.Port_B   = port_b_q;
  assign alu.ALUOP    = aluop_q;
  assign result_valid = valid_q;
  assign state_o      = state_q;

  always_comb begin
    case (state_q)
      ST_ENTER_A, ST_ENTER_B: disp_value = opnd;
      ST_ENTER_OP:            disp_value = {28'b0, sw[3:0]};
      ST_EXEC:                disp_value = alu.alu_out;
      ST_SHOW:                disp_value = result_q;
      default:                disp_value = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce window and a
// small behavioural ALU on the bus.
module tb_alu_operand_sequencer;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [17:0] sw = '0;
  logic        key_enter_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [31:0] result_q, disp_value;
  logic        zero_q, neg_q, ovf_q, result_valid;
  logic [2:0]  state_o;
  int          checks = 0;
  int          errors = 0;

  alu_operand_sequencer_if alu_bus ();

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .sw           (sw),
    .key_enter_n  (key_enter_n),
    .key_clear_n  (key_clear_n),
    .alu          (alu_bus),
    .result_q     (result_q),
    .zero_q       (zero_q),
    .neg_q        (neg_q),
    .ovf_q        (ovf_q),
    .result_valid (result_valid),
    .state_o      (state_o),
    .disp_value   (disp_value)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU
  always_comb begin
    logic [31:0] a, b, y;
    a = alu_bus.Port_A;
    b = alu_bus.Port_B;
    y = '0;
    case (alu_bus.ALUOP)
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
    alu_bus.alu_out  = y;
    alu_bus.alu_zero = (y == 32'd0);
    alu_bus.alu_neg  = y[31];
    alu_bus.alu_ovf  = (alu_bus.ALUOP == ALU_ADD) && (a[31] == b[31]) && (y[31] != a[31]);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_enter();
    key_enter_n = 1'b0;
    tick(8);
    key_enter_n = 1'b1;
    tick(8);
  endtask

  // Third press: stop in EXEC, check it, then one edge to SHOW
  task automatic press_to_exec(input logic [31:0] exp_res, input logic exp_zero);
    logic found;
    found = 1'b0;
    key_enter_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (state_o == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("exec_reached", 32'(found), 32'd1);
    check("exec_disp", disp_value, exp_res);
    check("exec_aluop", 32'(alu_bus.ALUOP), 32'(ALU_ADD));
    tick(1);
    check("show_state", 32'(state_o), 32'd4);
    check("show_result", result_q, exp_res);
    check("show_zero", 32'(zero_q), 32'(exp_zero));
    check("show_valid", 32'(result_valid), 32'd1);
    check("show_disp", disp_value, exp_res);
    key_enter_n = 1'b1;
    tick(8);
    check("show_hold", 32'(state_o), 32'd4);
  endtask

  initial begin
    logic saw_exec;
    // Reset
    sw = 18'h00005;
    tick(3);
    nRST = 1'b1;
    tick(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_port_a", alu_bus.Port_A, 32'd0);
    check("rst_port_b", alu_bus.Port_B, 32'd0);
    check("rst_aluop", 32'(alu_bus.ALUOP), 32'(ALU_SLL));
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result_q, 32'd0);
    check("rst_disp", disp_value, 32'h00000005);
    sw = 18'h18000;
    #1;
    check("rst_disp_sext", disp_value, 32'hFFFF8000);

    // 5 + 3 = 8
    sw = 18'h00005;
    press_enter();
    check("a_state", 32'(state_o), 32'd1);
    check("a_port", alu_bus.Port_A, 32'h00000005);
    sw = 18'h00003;
    press_enter();
    check("b_state", 32'(state_o), 32'd2);
    check("b_port", alu_bus.Port_B, 32'h00000003);
    sw = 18'h0FFF3;
    #1;
    check("op_disp", disp_value, 32'h00000003);
    press_to_exec(32'h00000008, 1'b0);

    // -1 + 1 = 0
    press_enter();
    check("show_to_a", 32'(state_o), 32'd0);
    check("retain_a", alu_bus.Port_A, 32'h00000005);
    sw = 18'h1FFFF;
    #1;
    check("disp_neg", disp_value, 32'hFFFFFFFF);
    press_enter();
    check("a2_port", alu_bus.Port_A, 32'hFFFFFFFF);
    sw = 18'h00001;
    press_enter();
    check("b2_port", alu_bus.Port_B, 32'h00000001);
    sw = 18'h00003;
    press_to_exec(32'h00000000, 1'b1);
    press_enter();
    check("back_to_a", 32'(state_o), 32'd0);

    // Glitch of 3 cycles must be rejected
    key_enter_n = 1'b0;
    tick(3);
    key_enter_n = 1'b1;
    tick(10);
    check("glitch_state", 32'(state_o), 32'd0);
    // 4 + SYNC cycles low: exactly one advance
    key_enter_n = 1'b0;
    tick(6);
    key_enter_n = 1'b1;
    tick(10);
    check("min_press_state", 32'(state_o), 32'd1);
    // Long hold: still one advance
    key_enter_n = 1'b0;
    tick(100);
    check("hold_state", 32'(state_o), 32'd2);
    key_enter_n = 1'b1;
    tick(10);
    check("hold_release", 32'(state_o), 32'd2);

    // Simultaneous clear and enter in ENTER_OP
    saw_exec = 1'b0;
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state_o == 3'd3) saw_exec = 1'b1;
    end
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state_o == 3'd3) saw_exec = 1'b1;
    end
    check("clr_no_exec", 32'(saw_exec), 32'd0);
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_port_a", alu_bus.Port_A, 32'd0);
    check("clr_port_b", alu_bus.Port_B, 32'd0);
    check("clr_aluop", 32'(alu_bus.ALUOP), 32'(ALU_SLL));
    check("clr_result", result_q, 32'd0);

    // Back to SHOW, then asynchronous reset between edges
    sw = 18'h00005;
    press_enter();
    sw = 18'h00003;
    press_enter();
    press_enter();
    check("pre_rst_state", 32'(state_o), 32'd4);
    check("pre_rst_result", result_q, 32'h00000008);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_result", result_q, 32'd0);
    check("arst_port_a", alu_bus.Port_A, 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_aluop", 32'(alu_bus.ALUOP), 32'(ALU_SLL));
    tick(3);
    nRST = 1'b1;
    tick(2);
    check("post_rst_state", 32'(state_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage feeding the board-level ALU; replaces direct switch-to-port wiring.
- Debounces two push-buttons and steps an entry state machine: operand A, operand B, ALU op, execute.
- Holds all ALU inputs stable and captures the ALU result and flags into registers.
- Provides one 32-bit display value for the downstream seven-segment stage.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- SYNC_STAGES, 2, synchronizer flops on each raw key input.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous, active-low reset.
- sw  input  18  raw switches.
  - sw[15:0] is the operand low half.
  - sw[16] is the sign-extend fill bit.
  - sw[3:0] is the op code in op-entry state.
  - sw[17] is unused.
- key_enter_n  input  1  raw active-low advance button.
- key_clear_n  input  1  raw active-low clear button.
- Port_A  output  32  ALU operand A.
- Port_B  output  32  ALU operand B.
- ALUOP  output  aluop_t  ALU operation.
- alu_out  input  32  ALU Output_Port.
- alu_zero, alu_neg, alu_ovf  input  1 each  ALU flags.
- result_q  output  32  captured result.
- zero_q, neg_q, ovf_q  output  1 each  captured flags.
- result_valid  output  1  high while in SHOW.
- state_o  output  3  current state encoding, for LEDs.
- disp_value  output  32  value for the hex display.

Behaviour:
- Reset (async, nRST low):
  - state ENTER_A.
  - Port_A, Port_B, result_q = 0; flags = 0.
  - ALUOP = ALU_SLL; result_valid = 0.
  - Synchronizers and debounced levels = 1 (released); debounce counters = 0.
- Operand formation: opnd = {{16{sw[16]}}, sw[15:0]}, sampled from raw sw (switches are quasi-static).
- Debounce, per key:
  - Synchronize the raw key; counter clears whenever sync == debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes sync and the counter clears.
  - A debounced 1->0 transition produces a one-cycle press pulse.
  - Press latency from a stable raw edge is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Release produces no pulse.
- FSM, transitions on press pulses:
  - ENTER_A: enter -> Port_A <= opnd, go ENTER_B.
  - ENTER_B: enter -> Port_B <= opnd, go ENTER_OP.
  - ENTER_OP: enter -> ALUOP <= sw[3:0] if it is a defined aluop_t code, else ALU_SLL; go EXEC.
  - EXEC: exactly one cycle, no key needed. On the exit edge, capture result_q <= alu_out and the flags; go SHOW. ALU inputs have been stable for at least one full cycle.
  - SHOW: result_valid = 1. Enter -> go ENTER_A; Port_A, Port_B, ALUOP and result_q are retained until overwritten.
- Clear pulse, any state:
  - Next state ENTER_A.
  - Port_A, Port_B, result_q and flags <= 0; ALUOP <= ALU_SLL.
  - Clear takes priority over a simultaneous enter pulse.
- Enter pulse in EXEC: ignored.
- Op entry does not reuse sw[16]; sw[15:4] are ignored in ENTER_OP.
- disp_value:
  - opnd in ENTER_A and ENTER_B.
  - {28'b0, sw[3:0]} in ENTER_OP.
  - result_q in SHOW.
  - alu_out in EXEC.
- state_o encoding: ENTER_A = 0, ENTER_B = 1, ENTER_OP = 2, EXEC = 3, SHOW = 4. Values 5-7 are illegal; on an illegal value the FSM recovers to ENTER_A.
- All outputs are registered except disp_value and state_o, which are combinational from registers and sw.

Decomposition:
- cpu_types_pkg: aluop_t and ALU_* constants, already shared and used unchanged.
- Add to cpu_types_pkg:
  - seq_state_t enum (3-bit, encodings above).
  - DEBOUNCE_DEFAULT constant.
- One sub-module, key_debouncer:
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES.
  - Ports: CLK, nRST, key_n, level, press.
  - Instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset held, then released with keys high -> state_o=0, Port_A=Port_B=0, ALUOP=ALU_SLL, result_valid=0, disp_value follows sw.
- A=0x0005 (sw16=0), B=0x0003, sw[3:0]=ALU_ADD code, enter pressed stably three times -> EXEC for one cycle, then SHOW with result_q=0x00000008, zero_q=0, result_valid=1.
- sw16=1, sw=0xFFFF, so A=0xFFFFFFFF; B=0x0001; op ALU_ADD -> Port_A=0xFFFFFFFF, result_q=0, zero_q=1.
- Enter glitch low for 3 cycles, then high -> no state change. Low for 4+SYNC cycles -> exactly one advance. Held low 100 cycles -> still only one advance.
- In ENTER_OP, clear and enter presses landing on the same cycle -> state ENTER_A, Port_A=Port_B=0, no EXEC.
- nRST asserted mid-SHOW (async, between edges) -> outputs zero immediately; after release, state_o=0.
